// File: rtl/load_store_unit.sv
// Load/store unit between the RV32I core datapath and a word-wide data memory.
// Converts byte/half/word loads and stores into aligned word accesses, extends
// load data, performs sub-word stores as a single-cycle read-modify-write and
// flags misaligned, illegal-size and out-of-range accesses.
// One transaction is in flight at a time: IDLE -> EXEC -> RESP -> IDLE.

module load_store_unit #(
    parameter int unsigned MEMORY_WORDS = 32'd1 << 16
) (
    input  logic        clk,
    input  logic        rst_n,

    // Core request channel
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,

    // Core response channel
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,

    // Word-wide data memory (combinational read, posedge write)
    output logic [31:0] mem_ra,
    input  logic [31:0] mem_rd,
    output logic        mem_we,
    output logic [31:0] mem_wa,
    output logic [31:0] mem_wd
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e      state_q;

    // Latched request
    logic        we_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;

    // Registered response
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    // Combinational next values
    logic        err_d;
    logic [31:0] load_data_d;
    logic [31:0] store_data_d;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Error classification of the incoming request, evaluated at accept time.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        err_d = 1'b0;
        if (req_size == 2'b11) begin
            err_d = 1'b1;
        end
        if (req_size == SIZE_HALF && req_addr[0] != 1'b0) begin
            err_d = 1'b1;
        end
        if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00) begin
            err_d = 1'b1;
        end
        if ({2'b00, req_addr[31:2]} >= MEMORY_WORDS) begin
            err_d = 1'b1;
        end
    end

    // Load lane selection and sign/zero extension from the addressed word.
    always_comb begin
        load_byte   = mem_rd[{addr_q[1:0], 3'b000} +: 8];
        load_half   = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
        load_data_d = mem_rd;
        case (size_q)
            SIZE_BYTE: load_data_d = unsigned_q ? {24'd0, load_byte}
                                                : {{24{load_byte[7]}}, load_byte};
            SIZE_HALF: load_data_d = unsigned_q ? {16'd0, load_half}
                                                : {{16{load_half[15]}}, load_half};
            default:   load_data_d = mem_rd;
        endcase
    end

    // Store data merge: the addressed byte/half replaces its lane in the current word.
    always_comb begin
        store_data_d = mem_rd;
        case (size_q)
            SIZE_BYTE: store_data_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            SIZE_HALF: store_data_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default:   store_data_d = wdata_q;
        endcase
    end

    // Transaction FSM: latches the request, executes for one cycle, holds the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        err_q      <= err_d;
                        state_q    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= err_q;
                    resp_rdata_q <= (we_q || err_q) ? 32'd0 : load_data_d;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= 32'd0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready is gated by rst_n so it reads low while reset is asserted even though the state is IDLE.
    assign req_ready  = rst_n && (state_q == ST_IDLE);

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    assign mem_ra = {addr_q[31:2], 2'b00};
    assign mem_wa = mem_ra;
    assign mem_wd = store_data_d;

    // NOTE: the write enable is gated directly by rst_n so asserting reset during EXEC kills the write at once.
    assign mem_we = rst_n && (state_q == ST_EXEC) && we_q && !err_q;

endmodule
